// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: write-back bypass into the read operands, load-use bubble
// insertion, branch flush, EX-side operand forwarding and a saturating stall counter.
module id_ex_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [XLEN-1:0]     id_pc,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [4:0]          id_rd,
    input  logic [XLEN-1:0]     id_rd1,
    input  logic [XLEN-1:0]     id_rd2,
    input  logic [XLEN-1:0]     id_imm,
    input  logic                id_reg_we,
    input  logic                id_mem_rd,
    input  logic                id_mem_we,
    input  logic                id_alu_src_b,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [1:0]          id_wb_sel,
    input  logic                flush,
    input  logic [4:0]          exm_rd,
    input  logic                exm_we,
    input  logic [XLEN-1:0]     exm_result,
    input  logic [4:0]          wb_rd,
    input  logic                wb_we,
    input  logic [XLEN-1:0]     wb_data,
    output logic                stall,
    output logic                ex_valid,
    output logic [XLEN-1:0]     ex_pc,
    output logic [XLEN-1:0]     ex_imm,
    output logic [4:0]          ex_rd,
    output logic                ex_reg_we,
    output logic                ex_mem_rd,
    output logic                ex_mem_we,
    output logic                ex_alu_src_b,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [1:0]          ex_wb_sel,
    output logic [XLEN-1:0]     ex_opa,
    output logic [XLEN-1:0]     ex_opb_reg,
    output logic [CNT_W-1:0]    stall_cnt
);

    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [XLEN-1:0] opa_p1;
    logic [XLEN-1:0] opb_p1;
    logic [XLEN-1:0] rd1_byp;
    logic [XLEN-1:0] rd2_byp;
    logic            hz;

    // A matching, enabled, non-x0 producer replaces the operand value.
    function automatic logic [XLEN-1:0] pick(input logic [4:0] rs, input logic we,
                                             input logic [4:0] rd, input logic [XLEN-1:0] data,
                                             input logic [XLEN-1:0] dflt);
        return (we && rd != 5'd0 && rd == rs) ? data : dflt;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

    assign rd1_byp = pick(id_rs1, wb_we, wb_rd, wb_data, id_rd1);
    assign rd2_byp = pick(id_rs2, wb_we, wb_rd, wb_data, id_rd2);

    assign hz = id_valid && ex_valid && ex_mem_rd && ex_rd != 5'd0 &&
                ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

    assign stall = rst_n && hz && !flush;

    // ID -> EX boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_reg_we    <= 1'b0;
            ex_mem_rd    <= 1'b0;
            ex_mem_we    <= 1'b0;
            ex_alu_src_b <= 1'b0;
            ex_alu_op    <= '0;
            ex_wb_sel    <= '0;
            opa_p1       <= '0;
            opb_p1       <= '0;
            stall_cnt    <= '0;
        end else if (flush || hz) begin
            // Bubble: control cleared, datapath fields keep their previous contents.
            ex_valid  <= 1'b0;
            ex_rd     <= '0;
            ex_reg_we <= 1'b0;
            ex_mem_rd <= 1'b0;
            ex_mem_we <= 1'b0;
            if (!flush) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_rd        <= id_rd;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_reg_we    <= id_reg_we && id_valid;
            ex_mem_rd    <= id_mem_rd;
            ex_mem_we    <= id_mem_we && id_valid;
            ex_alu_src_b <= id_alu_src_b;
            ex_alu_op    <= id_alu_op;
            ex_wb_sel    <= id_wb_sel;
            opa_p1       <= rd1_byp;
            opb_p1       <= rd2_byp;
        end
    end

    // EX forwarding: EX/MEM result wins over MEM/WB data.
    assign ex_opa     = pick(ex_rs1, exm_we, exm_rd, exm_result,
                             pick(ex_rs1, wb_we, wb_rd, wb_data, opa_p1));
    assign ex_opb_reg = pick(ex_rs2, exm_we, exm_rd, exm_result,
                             pick(ex_rs2, wb_we, wb_rd, wb_data, opb_p1));

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register of the five-stage RV32I core. It sits directly downstream of the register file and latches the decoded instruction plus both read operands. It bypasses same-cycle write-back data into the read operands, detects load-use hazards and inserts bubbles, and handles branch flushes. On the EX side it resolves the operand forwarding muxes, and it keeps a saturating load-use stall counter for the debug display.

Parameters:
XLEN, 32, datapath width
ALU_OP_W, 4, ALU opcode width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset: asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1, id_rs2  in  5 each  source register indices
id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1 / rs2
id_rd  in  5  destination index
id_rd1, id_rd2  in  XLEN each  register file RD1 / RD2
id_imm  in  XLEN  sign-extended immediate
id_reg_we, id_mem_rd, id_mem_we, id_alu_src_b  in  1 each  control bits
id_alu_op  in  ALU_OP_W  ALU operation
id_wb_sel  in  2  write-back source select
flush  in  1  branch/jump taken in EX; kill the ID instruction
exm_rd  in  5  EX/MEM destination
exm_we  in  1  EX/MEM register write enable
exm_result  in  XLEN  EX/MEM ALU result
wb_rd  in  5  MEM/WB destination (same as regfile wR)
wb_we  in  1  MEM/WB write enable (same as regfile WE)
wb_data  in  XLEN  write-back data (same as regfile wD)
stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_pc, ex_imm  out  XLEN  registered PC / immediate
ex_rd  out  5  registered destination
ex_reg_we, ex_mem_rd, ex_mem_we, ex_alu_src_b  out  1  registered control bits
ex_alu_op  out  ALU_OP_W  registered ALU op
ex_wb_sel  out  2  registered write-back select
ex_opa, ex_opb_reg  out  XLEN  forwarded rs1 / rs2 operands for EX
stall_cnt  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (async, rst_n=0): every ex_* register is 0, including ex_valid=0 and the registered rs1/rs2/operands. stall_cnt=0. stall=0 (stall is combinational and is also gated by rst_n).
- ID bypass (combinational, before the latch): the regfile write lands at the clock edge, so a same-cycle read returns the old value. If wb_we && wb_rd!=0 && wb_rd==id_rs1, the latched rs1 operand is wb_data, else id_rd1. The same rule applies to rs2.
- Load-use hazard: hz = id_valid && ex_valid && ex_mem_rd && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- Register update each posedge, in priority order:
  1. flush=1: bubble. ex_valid=0; reg_we, mem_rd, mem_we all 0; ex_rd=0. Datapath fields are don't-care but must hold their old values. stall=0 even if hz=1.
  2. hz=1: bubble as above. stall=1. stall_cnt increments and holds at all-ones (2^CNT_W-1).
  3. Otherwise: latch all id_* fields. If id_valid=0, latch with ex_valid=0 and write-side control bits forced to 0.
- A bubble can never drive mem_we or reg_we high.
- EX forwarding (combinational on the registered ex_rs1 / ex_rs2):
  - If exm_we && exm_rd!=0 && exm_rd==ex_rs1: ex_opa=exm_result.
  - Else if wb_we && wb_rd!=0 && wb_rd==ex_rs1: ex_opa=wb_data.
  - Else: the latched operand.
  - EX/MEM has priority over MEM/WB. ex_opb_reg uses the same rule with ex_rs2.
- Register x0 is never forwarded and never causes a hazard.
- Latency: one cycle from ID inputs to ex_* outputs. stall asserts in the same cycle as the hazard. A load-use pair costs exactly one bubble.
- Reset mid-operation clears the stage immediately. The first valid instruction after reset release is latched on the first posedge with rst_n=1.

Test Plan:
- Reset: rst_n=0 with every id_* input driven to nonzero values → all ex_* outputs 0, stall=0, stall_cnt=0. Release reset, latch one instruction → ex_valid=1 next cycle.
- WB→ID bypass: wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, id_rs1=5, id_rd1=0 → after the edge the registered rs1 operand is 0xDEADBEEF. Repeat with wb_rd=0 and id_rd1=0 → operand stays 0.
- Forwarding priority: ex_rs1=7, exm_rd=7 with exm_result=0x11, wb_rd=7 with wb_data=0x22 → ex_opa=0x11. Drop exm_we → ex_opa=0x22.
- Load-use: `lw x3` is in EX (ex_mem_rd=1, ex_rd=3) and `add x4,x3,x1` is in ID → stall=1 for exactly one cycle, then ex_valid=0 for one cycle, stall_cnt=1. The add enters EX next cycle with stall=0.
- Flush vs hazard: flush=1 in the same cycle as hz=1 → stall=0, ex_valid=0, stall_cnt unchanged.
- Saturation: with CNT_W=4, force 20 load-use hazards → stall_cnt=15 and holds there.
